// File: rtl/word_combiner.sv
// Purpose: rebuilds one OUT_WIDTH word from NUM_WORDS narrow words, word 0 in the LSBs.
// Latency: m_valid rises the cycle after the final-word handshake; full throughput.
// Backpressure: s_ready drops only on the final word while the output is held.
module word_combiner #(
    parameter int OUT_WIDTH  = 131,
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [WORD_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [OUT_WIDTH-1:0]  m_data,
    output logic                  err_frame
);

    localparam int NUM_WORDS = (OUT_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int TAIL_BITS = OUT_WIDTH - (NUM_WORDS - 1) * WORD_WIDTH;
    localparam int STAGE_W   = (NUM_WORDS - 1) * WORD_WIDTH;
    localparam int CNT_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [STAGE_W-1:0]   stage_q, stage_d;
    logic [OUT_WIDTH-1:0] m_data_q, m_data_d;
    logic                 m_valid_q, m_valid_d;
    logic                 err_q, err_d;

    logic at_last;
    logic s_hs;
    logic final_hs;
    logic early_last;

    // The staging buffer never waits on the output; only the final word
    // needs the output register to be free (or freeing this cycle).
    assign at_last    = (cnt_q == LAST_IDX);
    assign s_ready    = !at_last || !m_valid_q || m_ready;
    assign s_hs       = s_valid && s_ready;
    assign final_hs   = s_hs && at_last;
    assign early_last = s_hs && !at_last && s_last;

    // Next-state: counter, staging slot write, output load/drain, error pulse.
    always_comb begin
        cnt_d     = cnt_q;
        stage_d   = stage_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        err_d     = 1'b0;

        if (s_hs) begin
            if (at_last || s_last) begin
                // Final word completes a group; an early last drops the partial group.
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                for (int k = 0; k < NUM_WORDS - 1; k++) begin
                    if (cnt_q == CNT_W'(k)) begin
                        stage_d[k*WORD_WIDTH +: WORD_WIDTH] = s_data;
                    end
                end
            end
        end

        if (final_hs) begin
            m_data_d  = {s_data[TAIL_BITS-1:0], stage_q};
            m_valid_d = 1'b1;
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end

        // Missing last on the final word still produces output but is flagged.
        err_d = early_last || (final_hs && !s_last);
    end

    // State registers; reset discards any partial group and pending output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            stage_q   <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            stage_q   <= stage_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            err_q     <= err_d;
        end
    end

    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign err_frame = err_q;

endmodule

// File: tb/tb_word_combiner.sv
// Purpose: directed per-cycle vectors for word_combiner, plus backpressure and reset sequences.
// Latency: each step drives at negedge, checks s_ready before the edge, outputs after it.
// Backpressure: exercised by holding m_ready low across two full groups.
module tb_word_combiner;

    logic         clk;
    logic         rst;
    logic         s_valid;
    logic         s_ready;
    logic [31:0]  s_data;
    logic         s_last;
    logic         m_valid;
    logic         m_ready;
    logic [130:0] m_data;
    logic         err_frame;

    int n_cmp;
    int n_bad;

    word_combiner #(.OUT_WIDTH(131), .WORD_WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .err_frame (err_frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         v;
        logic [31:0]  d;
        logic         l;
        logic         mr;
        logic         esr;
        logic         emv;
        logic [130:0] emd;
        logic         eerr;
    } vec_t;

    vec_t vecs[$];

    localparam logic [130:0] D1 = 131'h5_00000004_00000003_00000002_00000001;
    localparam logic [130:0] D2 = 131'h2_00000044_00000033_00000022_00000011;
    localparam logic [130:0] D3 = 131'h7_A3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
    localparam logic [130:0] D4 = 131'h4_C3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0;
    localparam logic [130:0] D5 = 131'h1_D3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0;
    localparam logic [130:0] DE = 131'h3_E3E3E3E3_E2E2E2E2_E1E1E1E1_E0E0E0E0;
    localparam logic [130:0] DF = 131'h5_F3F3F3F3_F2F2F2F2_F1F1F1F1_F0F0F0F0;
    localparam logic [130:0] DG = 131'h6_04040404_03030303_02020202_01010101;
    localparam logic [130:0] DS = 131'h7_0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A;

    task automatic add(input logic v, input logic [31:0] d, input logic l, input logic mr,
                       input logic esr, input logic emv, input logic [130:0] emd,
                       input logic eerr);
        vec_t t;
        t.v = v; t.d = d; t.l = l; t.mr = mr;
        t.esr = esr; t.emv = emv; t.emd = emd; t.eerr = eerr;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input string field,
                       input logic [130:0] got, input logic [130:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s %s: got %0h required %0h", name, field, got, want);
        end
    endtask

    // One clock: drive at negedge, check s_ready pre-edge, registered outputs after.
    task automatic cyc(input string name, input logic v, input logic [31:0] d,
                       input logic l, input logic mr, input logic esr, input logic emv,
                       input logic [130:0] emd, input logic eerr);
        s_valid = v;
        s_data  = d;
        s_last  = l;
        m_ready = mr;
        #1;
        chk(name, "s_ready", 131'(s_ready), 131'(esr));
        @(posedge clk);
        #1;
        chk(name, "m_valid", 131'(m_valid), 131'(emv));
        chk(name, "m_data", m_data, emd);
        chk(name, "err_frame", 131'(err_frame), 131'(eerr));
        @(negedge clk);
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        m_ready = 1'b1;

        // Basic group, then back-to-back groups with m_ready high.
        add(1, 32'h00000001, 0, 1, 1, 0, '0, 0);
        add(1, 32'h00000002, 0, 1, 1, 0, '0, 0);
        add(1, 32'h00000003, 0, 1, 1, 0, '0, 0);
        add(1, 32'h00000004, 0, 1, 1, 0, '0, 0);
        add(1, 32'hFFFFFFFD, 1, 1, 1, 1, D1, 0);
        add(1, 32'h00000011, 0, 1, 1, 0, D1, 0);
        add(1, 32'h00000022, 0, 1, 1, 0, D1, 0);
        add(1, 32'h00000033, 0, 1, 1, 0, D1, 0);
        add(1, 32'h00000044, 0, 1, 1, 0, D1, 0);
        add(1, 32'h00000002, 1, 1, 1, 1, D2, 0);
        add(1, 32'hA0A0A0A0, 0, 1, 1, 0, D2, 0);
        add(1, 32'hA1A1A1A1, 0, 1, 1, 0, D2, 0);
        add(1, 32'hA2A2A2A2, 0, 1, 1, 0, D2, 0);
        add(1, 32'hA3A3A3A3, 0, 1, 1, 0, D2, 0);
        add(1, 32'hFFFFFFFF, 1, 1, 1, 1, D3, 0);
        // Early last on the third word: error pulse, no output.
        add(1, 32'hB0B0B0B0, 0, 1, 1, 0, D3, 0);
        add(1, 32'hB1B1B1B1, 0, 1, 1, 0, D3, 0);
        add(1, 32'hB2B2B2B2, 1, 1, 1, 0, D3, 1);
        // Recovery group, with an idle cycle carrying junk data and last.
        add(1, 32'hC0C0C0C0, 0, 1, 1, 0, D3, 0);
        add(1, 32'hC1C1C1C1, 0, 1, 1, 0, D3, 0);
        add(0, 32'hDEADBEEF, 1, 1, 1, 0, D3, 0);
        add(1, 32'hC2C2C2C2, 0, 1, 1, 0, D3, 0);
        add(1, 32'hC3C3C3C3, 0, 1, 1, 0, D3, 0);
        add(1, 32'h00000004, 1, 1, 1, 1, D4, 0);
        // Missing last on the fifth word: output plus error pulse.
        add(1, 32'hD0D0D0D0, 0, 1, 1, 0, D4, 0);
        add(1, 32'hD1D1D1D1, 0, 1, 1, 0, D4, 0);
        add(1, 32'hD2D2D2D2, 0, 1, 1, 0, D4, 0);
        add(1, 32'hD3D3D3D3, 0, 1, 1, 0, D4, 0);
        add(1, 32'h12345679, 0, 1, 1, 1, D5, 1);
        add(0, 32'h00000000, 0, 1, 1, 0, D5, 0);

        // Reset state (asynchronous, checked while clock runs with rst high).
        #2;
        chk("reset", "m_valid", 131'(m_valid), 131'(0));
        chk("reset", "m_data", m_data, '0);
        chk("reset", "err_frame", 131'(err_frame), 131'(0));
        chk("reset", "s_ready", 131'(s_ready), 131'(1));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            cyc($sformatf("vec%0d", i), vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].mr,
                vecs[i].esr, vecs[i].emv, vecs[i].emd, vecs[i].eerr);
        end

        // Backpressure: two groups with m_ready low, then release.
        cyc("bp_e0", 1, 32'hE0E0E0E0, 0, 0, 1, 0, D5, 0);
        cyc("bp_e1", 1, 32'hE1E1E1E1, 0, 0, 1, 0, D5, 0);
        cyc("bp_e2", 1, 32'hE2E2E2E2, 0, 0, 1, 0, D5, 0);
        cyc("bp_e3", 1, 32'hE3E3E3E3, 0, 0, 1, 0, D5, 0);
        cyc("bp_e4", 1, 32'h00000003, 1, 0, 1, 1, DE, 0);
        cyc("bp_f0", 1, 32'hF0F0F0F0, 0, 0, 1, 1, DE, 0);
        cyc("bp_f1", 1, 32'hF1F1F1F1, 0, 0, 1, 1, DE, 0);
        cyc("bp_f2", 1, 32'hF2F2F2F2, 0, 0, 1, 1, DE, 0);
        cyc("bp_f3", 1, 32'hF3F3F3F3, 0, 0, 1, 1, DE, 0);
        cyc("bp_f4_stall0", 1, 32'h00000005, 1, 0, 0, 1, DE, 0);
        cyc("bp_f4_stall1", 1, 32'h00000005, 1, 0, 0, 1, DE, 0);
        cyc("bp_f4_go", 1, 32'h00000005, 1, 1, 1, 1, DF, 0);
        cyc("bp_drain", 0, 32'h00000000, 0, 1, 1, 0, DF, 0);

        // Reset with a pending output and a partial group.
        cyc("rs_g0", 1, 32'h01010101, 0, 0, 1, 0, DF, 0);
        cyc("rs_g1", 1, 32'h02020202, 0, 0, 1, 0, DF, 0);
        cyc("rs_g2", 1, 32'h03030303, 0, 0, 1, 0, DF, 0);
        cyc("rs_g3", 1, 32'h04040404, 0, 0, 1, 0, DF, 0);
        cyc("rs_g4", 1, 32'h00000006, 1, 0, 1, 1, DG, 0);
        cyc("rs_r0", 1, 32'h55555555, 0, 0, 1, 1, DG, 0);
        cyc("rs_r1", 1, 32'h66666666, 0, 0, 1, 1, DG, 0);
        s_valid = 1'b0;
        rst     = 1'b1;
        #1;
        chk("midrst", "m_valid", 131'(m_valid), 131'(0));
        chk("midrst", "m_data", m_data, '0);
        chk("midrst", "err_frame", 131'(err_frame), 131'(0));
        chk("midrst", "s_ready", 131'(s_ready), 131'(1));
        @(negedge clk);
        rst = 1'b0;
        cyc("rs_s0", 1, 32'h0A0A0A0A, 0, 1, 1, 0, '0, 0);
        cyc("rs_s1", 1, 32'h0B0B0B0B, 0, 1, 1, 0, '0, 0);
        cyc("rs_s2", 1, 32'h0C0C0C0C, 0, 1, 1, 0, '0, 0);
        cyc("rs_s3", 1, 32'h0D0D0D0D, 0, 1, 1, 0, '0, 0);
        cyc("rs_s4", 1, 32'h00000007, 1, 1, 1, 1, DS, 0);
        cyc("rs_idle", 0, 32'h00000000, 0, 1, 1, 0, DS, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
